// File: rtl/rx_tag_framer_pkg.sv
// rtl/rx_tag_framer_pkg.sv - shared types and constants for the RX tag framer
package rx_tag_framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        WR_I,
        WR_Q
    } state_t;

    localparam int          WORD_W         = 16;
    localparam int          DROP_W         = 8;
    localparam logic [15:0] HEADER_DEFAULT = 16'hA5A5;

endpackage

// File: rtl/rx_tag_framer_if.sv
// rtl/rx_tag_framer_if.sv - sample input, FIFO write and status signals of the RX tag framer
interface rx_tag_framer_if
    import rx_tag_framer_pkg::*;
#(
    parameter int SEQ_W = 16
);

    logic              strobe;
    logic              tag;
    logic [WORD_W-1:0] i_data;
    logic [WORD_W-1:0] q_data;
    logic              fifo_full;
    logic              clear_overrun;
    logic [WORD_W-1:0] fifo_wdata;
    logic              fifo_we;
    logic              overrun;
    logic [DROP_W-1:0] drop_count;
    logic [SEQ_W-1:0]  seq_num;

    // sample source, FIFO and control software side
    modport master (
        output strobe, tag, i_data, q_data, fifo_full, clear_overrun,
        input  fifo_wdata, fifo_we, overrun, drop_count, seq_num
    );

    // framer side
    modport slave (
        input  strobe, tag, i_data, q_data, fifo_full, clear_overrun,
        output fifo_wdata, fifo_we, overrun, drop_count, seq_num
    );

endinterface

// File: rtl/rx_tag_framer_sat_counter.sv
// rtl/rx_tag_framer_sat_counter.sv - saturating event counter with clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // clear restarts at one when an event lands in the same cycle, so no event is lost
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? ONE : '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/rx_tag_framer.sv
// rtl/rx_tag_framer.sv - serialises strobed I/Q pairs into FIFO words with window headers
module rx_tag_framer
    import rx_tag_framer_pkg::*;
#(
    parameter logic [15:0] HEADER = HEADER_DEFAULT,
    parameter int          SEQ_W  = 16
) (
    input  logic           clk,
    input  logic           reset,
    rx_tag_framer_if.slave bus
);

    state_t            state;
    logic [WORD_W-1:0] cap_i;
    logic [WORD_W-1:0] cap_q;
    logic [SEQ_W-1:0]  seq_cnt;
    logic [WORD_W-1:0] wdata;
    logic              we;
    logic              ovr;
    logic              ready;
    logic              accept;
    logic              drop;
    logic [WORD_W-1:0] seq_word;

    // a new pair is taken when idle, or when the last word of the current pair leaves this cycle
    assign ready    = (state == IDLE) || ((state == WR_Q) && !bus.fifo_full);
    assign accept   = bus.strobe && ready;
    assign drop     = bus.strobe && !ready;
    assign seq_word = WORD_W'(seq_cnt);

    assign bus.fifo_wdata = wdata;
    assign bus.fifo_we    = we;
    assign bus.overrun    = ovr;
    assign bus.seq_num    = seq_cnt;

    // framing FSM: each write state emits one word per non-full cycle and holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cap_i   <= '0;
            cap_q   <= '0;
            seq_cnt <= '0;
            wdata   <= '0;
            we      <= 1'b0;
        end else begin
            if (accept) begin
                cap_i <= bus.i_data;
                cap_q <= bus.q_data;
            end
            case (state)
                IDLE: begin
                    we <= 1'b0;
                    if (accept) begin
                        state <= bus.tag ? HDR : WR_I;
                    end
                end
                HDR: begin
                    if (!bus.fifo_full) begin
                        we    <= 1'b1;
                        wdata <= HEADER;
                        state <= SEQ;
                    end else begin
                        we <= 1'b0;
                    end
                end
                SEQ: begin
                    if (!bus.fifo_full) begin
                        we      <= 1'b1;
                        wdata   <= seq_word;
                        seq_cnt <= seq_cnt + 1'b1;
                        state   <= WR_I;
                    end else begin
                        we <= 1'b0;
                    end
                end
                WR_I: begin
                    if (!bus.fifo_full) begin
                        we    <= 1'b1;
                        wdata <= cap_i;
                        state <= WR_Q;
                    end else begin
                        we <= 1'b0;
                    end
                end
                WR_Q: begin
                    if (!bus.fifo_full) begin
                        we    <= 1'b1;
                        wdata <= cap_q;
                        if (accept) begin
                            state <= bus.tag ? HDR : WR_I;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        we <= 1'b0;
                    end
                end
                default: begin
                    we    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // sticky overrun flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr <= 1'b0;
        end else if (drop) begin
            ovr <= 1'b1;
        end else if (bus.clear_overrun) begin
            ovr <= 1'b0;
        end
    end

    sat_counter #(
        .W (DROP_W)
    ) u_drop_count (
        .clk   (clk),
        .reset (reset),
        .inc   (drop),
        .clr   (bus.clear_overrun),
        .count (bus.drop_count)
    );

endmodule

// File: tb/tb_rx_tag_framer.sv
// tb/tb_rx_tag_framer.sv - self-checking bench for rx_tag_framer against a word-queue model
module tb_rx_tag_framer;

    localparam logic [15:0] EXP_HEADER = 16'hA5A5;

    typedef struct {
        logic [15:0] d;
        bit          is_seq;
    } word_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rx_tag_framer_if #(.SEQ_W(16)) bus ();

    rx_tag_framer #(
        .HEADER (16'hA5A5),
        .SEQ_W  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // reference model: the queue of words still owed to the FIFO
    word_t       pend[$];
    bit          m_we;
    logic [15:0] m_wdata;
    bit          m_ovr;
    int          m_drop;
    logic [15:0] m_seq;
    logic [15:0] m_hdrs;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] d, input bit is_seq);
        word_t w;
        w.d      = d;
        w.is_seq = is_seq;
        pend.push_back(w);
    endtask

    task automatic cycle(input bit s, input bit t, input logic [15:0] i, input logic [15:0] q,
                         input bit full, input bit clr, input bit rst);
        word_t w;
        bit    ready;
        @(negedge clk);
        reset             = rst;
        bus.strobe        = s;
        bus.tag           = t;
        bus.i_data        = i;
        bus.q_data        = q;
        bus.fifo_full     = full;
        bus.clear_overrun = clr;
        if (rst) begin
            pend.delete();
            m_we    = 1'b0;
            m_wdata = '0;
            m_ovr   = 1'b0;
            m_drop  = 0;
            m_seq   = '0;
            m_hdrs  = '0;
        end else begin
            // room for a new pair: nothing owed, or only the final word owed and it leaves now
            ready = (pend.size() == 0) || ((pend.size() == 1) && !full);
            m_we  = 1'b0;
            if (!full && (pend.size() > 0)) begin
                w       = pend.pop_front();
                m_we    = 1'b1;
                m_wdata = w.d;
                if (w.is_seq) m_seq++;
            end
            if (clr) begin
                m_ovr  = 1'b0;
                m_drop = 0;
            end
            if (s) begin
                if (ready) begin
                    if (t) begin
                        push_word(EXP_HEADER, 1'b0);
                        push_word(m_hdrs, 1'b1);
                        m_hdrs++;
                    end
                    push_word(i, 1'b0);
                    push_word(q, 1'b0);
                end else begin
                    m_ovr = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        @(posedge clk);
        #1;
        check("fifo_we", bus.fifo_we, m_we);
        check("fifo_wdata", bus.fifo_wdata, m_wdata);
        check("overrun", bus.overrun, m_ovr);
        check("drop_count", bus.drop_count, m_drop);
        check("seq_num", bus.seq_num, m_seq);
    endtask

    task automatic idle(input int n, input bit full);
        repeat (n) cycle(1'b0, 1'b0, 16'h0, 16'h0, full, 1'b0, 1'b0);
    endtask

    task automatic strb(input bit t, input logic [15:0] i, input logic [15:0] q, input bit full);
        cycle(1'b1, t, i, q, full, 1'b0, 1'b0);
    endtask

    initial begin
        reset             = 1'b1;
        bus.strobe        = 1'b0;
        bus.tag           = 1'b0;
        bus.i_data        = '0;
        bus.q_data        = '0;
        bus.fifo_full     = 1'b0;
        bus.clear_overrun = 1'b0;

        // reset state
        cycle(0, 0, 16'h0, 16'h0, 0, 0, 1);
        cycle(0, 0, 16'h0, 16'h0, 0, 0, 1);
        idle(2, 0);

        // untagged strobes every 64 clocks
        for (int k = 0; k < 4; k++) begin
            strb(0, 16'h1234, 16'h5678, 0);
            idle(63, 0);
        end

        // tagged window followed by two untagged strobes at minimum spacing
        strb(1, 16'($urandom), 16'($urandom), 0);
        idle(3, 0);
        strb(0, 16'($urandom), 16'($urandom), 0);
        idle(1, 0);
        strb(0, 16'($urandom), 16'($urandom), 0);
        idle(3, 0);
        // second window carries sequence 0001
        strb(1, 16'($urandom), 16'($urandom), 0);
        idle(6, 0);

        // fifo_full for 3 cycles while I is pending
        strb(0, 16'($urandom), 16'($urandom), 0);
        idle(3, 1);
        idle(4, 0);

        // strobe 2 clocks after a tagged strobe is dropped, then cleared
        strb(1, 16'($urandom), 16'($urandom), 0);
        idle(1, 0);
        strb(0, 16'($urandom), 16'($urandom), 0);
        idle(6, 0);
        cycle(0, 0, 16'h0, 16'h0, 0, 1, 0);
        idle(2, 0);

        // 300 strobes against a permanently full FIFO saturate the drop count
        strb(0, 16'($urandom), 16'($urandom), 1);
        for (int k = 0; k < 300; k++) begin
            strb(1'($urandom), 16'($urandom), 16'($urandom), 1);
        end
        idle(3, 1);
        idle(5, 0);

        // clear and drop in the same cycle: drop wins
        cycle(0, 0, 16'h0, 16'h0, 0, 1, 0);
        strb(0, 16'($urandom), 16'($urandom), 0);
        cycle(1, 1, 16'($urandom), 16'($urandom), 0, 1, 0);
        idle(3, 0);

        // reset while the SEQ word is pending abandons the frame
        strb(1, 16'($urandom), 16'($urandom), 0);
        idle(1, 0);
        cycle(0, 0, 16'h0, 16'h0, 0, 0, 1);
        idle(2, 0);
        strb(1, 16'($urandom), 16'($urandom), 0);
        idle(6, 0);

        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            cycle($urandom_range(0, 2) == 0, 1'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0, 1'b0);
        end
        idle(10, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_tag_framer.md
# rx_tag_framer

Receive-path framing stage that sits directly downstream of `data_tag` and upstream of the RX FIFO. It captures each strobed I/Q sample pair and serialises it into 16-bit FIFO words. When `tag` marks the first sample of an enable window, it prefixes that sample with a header word and a window sequence number, so host software can realign sample windows. It stalls on FIFO full, and it detects and counts strobes that arrive while it is busy.

## Interface
- `HEADER`, 16'hA5A5: marker word written ahead of every tagged sample.
- `SEQ_W`, 16: width of the window sequence counter (written zero-extended/truncated to 16 bits).
- `clk`, in, 1: system clock; all logic is rising-edge.
- `reset`, in, 1: synchronous, active-high reset.
- `strobe`, in, 1: sample valid, one clock wide (from `strobe_gen`).
- `tag`, in, 1: from `data_tag`; meaningful only when `strobe`=1, and marks a window-start sample.
- `i_data`, in, 16: I sample, valid with `strobe`.
- `q_data`, in, 16: Q sample, valid with `strobe`.
- `fifo_full`, in, 1: RX FIFO cannot accept a word this cycle.
- `clear_overrun`, in, 1: clears `overrun` and `drop_count`.
- `fifo_wdata`, out, 16: FIFO write data.
- `fifo_we`, out, 1: FIFO write enable; never asserted while `fifo_full`=1.
- `overrun`, out, 1: sticky; set when a strobe was dropped.
- `drop_count`, out, 8: dropped-strobe count, saturating at 255.
- `seq_num`, out, SEQ_W: number of headers emitted so far.

## Operation
- States: IDLE, HDR, SEQ, WR_I, WR_Q.
- Accept condition `ready` = (state==IDLE) or (state==WR_Q and !fifo_full).
- On `strobe`=1 with `ready`:
  - `i_data`, `q_data` and `tag` are registered.
  - Next state is HDR if `tag`=1, otherwise WR_I.
- HDR: write `HEADER`, then go to SEQ.
- SEQ: write `seq_num` (16 bits), increment `seq_num` (wraps at 2^SEQ_W), then go to WR_I.
- WR_I: write captured I, then go to WR_Q.
- WR_Q: write captured Q.
  - Next state is IDLE, or HDR/WR_I if a new strobe is accepted in the same cycle.
- Stall: in any write state with `fifo_full`=1, hold state, deassert `fifo_we`, and keep `fifo_wdata` unchanged.
- Drop: on `strobe`=1 with `ready`=0:
  - The sample is discarded and the captured data is unchanged.
  - `overrun` is set to 1.
  - `drop_count` increments, saturating at 255.
- A strobe with `tag`=1 that is dropped loses its header. `seq_num` does not advance for it.
- `clear_overrun` and a drop in the same cycle: the drop wins, giving `overrun`=1 and `drop_count`=1.
- `tag` without `strobe`: ignored.

## Timing
- Reset values: state IDLE, `fifo_we`=0, `fifo_wdata`=0, `overrun`=0, `drop_count`=0, `seq_num`=0, capture registers 0.
- Reset mid-frame abandons the frame; no partial words are written after the reset cycle.
- Latency: strobe accepted at edge N. The first `fifo_we` is in cycle N+1 (HDR or I).
- Untagged sample with no stall: I at N+1, Q at N+2. The minimum strobe spacing without drop is 2 clocks.
- Tagged sample with no stall: HDR N+1, SEQ N+2, I N+3, Q N+4. The minimum spacing after a tagged strobe is 4 clocks.
- Each `fifo_full` cycle during a write state adds exactly one cycle of delay.
- `fifo_we` and `fifo_wdata` are registered outputs.

## Structure
- Package `rx_tag_framer_pkg`: state enum (IDLE, HDR, SEQ, WR_I, WR_Q), default `HEADER` constant, `DROP_W`=8.
- Sub-module `sat_counter` (parameterised width, inc, clr, saturating) is used for `drop_count`.
- The remainder is a single FSM with its datapath.

## Test plan
- Untagged strobes every 64 clocks, I=16'h1234, Q=16'h5678: the writes are 1234 then 5678 at N+1/N+2; `overrun` stays 0.
- Tagged strobe, then two untagged strobes: the writes are A5A5, 0000, I, Q, I, Q, I, Q and `seq_num`=1. A second tagged window produces 0001 in the SEQ slot.
- `fifo_full` held for 3 cycles during WR_I: I is written exactly once, 3 cycles late; no duplicate or lost words.
- Strobe 2 clocks after a tagged strobe: `overrun`=1 and `drop_count`=1; the stream contains only the first frame. Then pulse `clear_overrun`: both return to 0.
- 300 strobes while `fifo_full`=1 permanently: `drop_count` saturates at 255, `fifo_we` is never asserted, and the held frame completes after `fifo_full` drops.
- `reset` pulsed during SEQ: the next cycle shows `fifo_we`=0 and `seq_num`=0. The next tagged strobe emits A5A5, 0000.
